// File: rtl/alu_result_checker.sv
// alu_result_checker: snoops ALU issues, compares C against the expected result LATENCY edges later.
// Define ALU_CHK_HALT_EN to freeze all checking after the first mismatch until rst or clear.
module alu_result_checker #(
   parameter int LATENCY = 1,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             in_valid,
   input  logic [3:0]       A,
   input  logic [3:0]       B,
   input  logic [1:0]       op_code,
   input  logic [4:0]       C,
   output logic             check_valid,
   output logic             check_pass,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic             fail_flag,
   output logic [1:0]       first_fail_op,
   output logic [4:0]       first_fail_exp,
   output logic [4:0]       first_fail_got,
   output logic             busy
);
   if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
      $error("alu_result_checker: LATENCY must be within 1..8");
   end
   logic [LATENCY-1:0] vld;
   logic [1:0]         op_p  [LATENCY];
   logic [4:0]         exp_p [LATENCY];
   logic [4:0]         exp_v;
   logic               halt, take, cmp, match;
`ifdef ALU_CHK_HALT_EN
   assign halt = fail_flag;
`else
   assign halt = 1'b0;
`endif
   assign exp_v = op_code == 2'd0 ? {1'b0, A} + {1'b0, B} :
                  op_code == 2'd1 ? {1'b0, A} - {1'b0, B} :
                  op_code == 2'd2 ? {4'd0, A == B} : {4'd0, A < B};
   assign take  = in_valid & ~halt;
   assign cmp   = vld[LATENCY-1] & ~halt;
   assign match = C == exp_p[LATENCY-1];
   assign busy  = |vld & ~halt;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            op_p[i]  <= '0;
            exp_p[i] <= '0;
         end
      end else if (clear) begin
         vld <= '0;
      end else begin
         vld[0]   <= take;
         op_p[0]  <= op_code;
         exp_p[0] <= exp_v;
         for (int i = 1; i < LATENCY; i++) begin
            vld[i]   <= vld[i-1];
            op_p[i]  <= op_p[i-1];
            exp_p[i] <= exp_p[i-1];
         end
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst || clear) begin
         check_valid    <= 1'b0;
         check_pass     <= 1'b0;
         pass_cnt       <= '0;
         fail_cnt       <= '0;
         fail_flag      <= 1'b0;
         first_fail_op  <= '0;
         first_fail_exp <= '0;
         first_fail_got <= '0;
      end else begin
         check_valid <= cmp;
         if (cmp) begin
            check_pass <= match;
            // counters stick at all-ones instead of wrapping
            if (match) pass_cnt <= pass_cnt + CNT_W'(~&pass_cnt);
            else begin
               fail_cnt <= fail_cnt + CNT_W'(~&fail_cnt);
               if (!fail_flag) begin
                  fail_flag      <= 1'b1;
                  first_fail_op  <= op_p[LATENCY-1];
                  first_fail_exp <= exp_p[LATENCY-1];
                  first_fail_got <= C;
               end
            end
         end
      end
   end
endmodule
